// File: rtl/seq_detect_arb.sv
// Two-requester round-robin arbiter feeding a shared serial pattern detector.
// Optional match counter output enabled by defining SEQ_DETECT_ARB_MATCH_CNT_EN.
module seq_detect_arb #(
    parameter int unsigned FRAME_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            req,
    input  logic [FRAME_BITS-1:0] word0,
    input  logic [FRAME_BITS-1:0] word1,
    input  logic [FRAME_BITS-1:0] pattern,
    output logic [1:0]            gnt,
    output logic                  a,
    output logic                  busy,
    output logic                  done,
    output logic                  hit
`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
    ,
    output logic [7:0]            match_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                state, state_d;
    logic [FRAME_BITS-1:0] word_q, word_d;
    logic [FRAME_BITS-1:0] pat_q, pat_d;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [CNT_W-1:0]      bitcnt, bitcnt_d;
    logic                  ptr, ptr_d;
    logic                  owner, owner_d;
    logic [1:0]            gnt_d;
    logic                  a_d, busy_d, done_d, hit_d;
    logic                  win;

    // Lone requester always wins; on contention the pointer decides.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            win = ptr;
        end
    end

    always_comb begin
        state_d  = state;
        word_d   = word_q;
        pat_d    = pat_q;
        rx_d     = rx_q;
        bitcnt_d = bitcnt;
        ptr_d    = ptr;
        owner_d  = owner;
        gnt_d    = gnt;
        a_d      = 1'b0;
        done_d   = 1'b0;
        hit_d    = 1'b0;

        case (state)
            IDLE: begin
                gnt_d = 2'b00;
                if (req != 2'b00) begin
                    state_d  = SHIFT;
                    owner_d  = win;
                    word_d   = win ? word1 : word0;
                    pat_d    = pattern;
                    rx_d     = '0;
                    bitcnt_d = '0;
                    gnt_d    = win ? 2'b10 : 2'b01;
                    a_d      = word_d[0];
                end
            end
            SHIFT: begin
                // Output bit is registered one edge ahead so a tracks word_q[bitcnt].
                bitcnt_d = bitcnt + CNT_W'(1);
                rx_d     = {word_q[bitcnt], rx_q[FRAME_BITS-1:1]};
                if (bitcnt == LAST_BIT) begin
                    state_d  = REPORT;
                    bitcnt_d = '0;
                    done_d   = 1'b1;
                    hit_d    = (rx_d == pat_q);
                end else begin
                    a_d = word_q[bitcnt_d];
                end
            end
            REPORT: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                ptr_d   = ~owner;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            word_q <= '0;
            pat_q  <= '0;
            rx_q   <= '0;
            bitcnt <= '0;
            ptr    <= 1'b0;
            owner  <= 1'b0;
            gnt    <= 2'b00;
            a      <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hit    <= 1'b0;
        end else begin
            state  <= state_d;
            word_q <= word_d;
            pat_q  <= pat_d;
            rx_q   <= rx_d;
            bitcnt <= bitcnt_d;
            ptr    <= ptr_d;
            owner  <= owner_d;
            gnt    <= gnt_d;
            a      <= a_d;
            busy   <= busy_d;
            done   <= done_d;
            hit    <= hit_d;
        end
    end

`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
    // Saturating count of matching frames.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            match_cnt <= 8'd0;
        end else if (done && hit && (match_cnt != 8'hFF)) begin
            match_cnt <= match_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seq_detect_arb.sv
// Scoreboard bench for seq_detect_arb: driver queues expected frames, monitor checks on done.
// Define SEQ_DETECT_ARB_MATCH_CNT_EN to also exercise the match counter.
module tb_seq_detect_arb;

    localparam int unsigned FB = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [FB-1:0] word0 = '0;
    logic [FB-1:0] word1 = '0;
    logic [FB-1:0] pattern = '0;
    logic [1:0]    gnt;
    logic          a, busy, done, hit;
`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
    logic [7:0]    match_cnt;
`endif

    seq_detect_arb #(.FRAME_BITS(FB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .word0     (word0),
        .word1     (word1),
        .pattern   (pattern),
        .gnt       (gnt),
        .a         (a),
        .busy      (busy),
        .done      (done),
        .hit       (hit)
`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    gnt;
        logic [FB-1:0] bits;
        logic          hit;
        int            spacing;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [1:0] g, input logic [FB-1:0] b, input logic h,
                                input int sp);
        exp_t e;
        e.gnt = g;
        e.bits = b;
        e.hit = h;
        e.spacing = sp;
        q.push_back(e);
    endtask

    // Issue one frame from IDLE, drop req after the grant edge, return in IDLE.
    task automatic frame(input logic [1:0] r, input logic [FB-1:0] w0, input logic [FB-1:0] w1,
                         input logic [FB-1:0] p, input logic [1:0] eg, input logic [FB-1:0] eb,
                         input logic eh, input int sp);
        expect_frame(eg, eb, eh, sp);
        req = r;
        word0 = w0;
        word1 = w1;
        pattern = p;
        @(posedge clk);
        #1 req = 2'b00;
        repeat (FB + 1) @(posedge clk);
        #1;
    endtask

    // Monitor: assemble each frame from the grant edge and score it on done.
    int            cyc = 0;
    int            last_grant = 0;
    int            spacing = 0;
    int            nbits = 0;
    logic [1:0]    prev_gnt = 2'b00;
    logic [1:0]    cur_gnt = 2'b00;
    logic [15:0]   abits = '0;
    bit            in_frame = 1'b0;
    bit            post_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en) begin
            if (done !== 1'b1) check("hit_outside_report", int'(hit), 0);
            if (post_done) begin
                check("done_one_cycle", int'(done), 0);
                check("gnt_after_report", int'(gnt), 0);
                check("busy_after_report", int'(busy), 0);
                post_done = 1'b0;
            end
            if (gnt != 2'b00 && prev_gnt == 2'b00) begin
                in_frame = 1'b1;
                cur_gnt = gnt;
                abits = '0;
                nbits = 0;
                spacing = cyc - last_grant;
                last_grant = cyc;
            end else if (gnt == 2'b00 && done !== 1'b1) begin
                in_frame = 1'b0;
            end
            if (in_frame && done !== 1'b1) begin
                check("busy_in_shift", int'(busy), 1);
                if (nbits < 16) abits[nbits] = a;
                nbits++;
            end
            if (done === 1'b1) begin
                check("a_in_report", int'(a), 0);
                check("busy_in_report", int'(busy), 1);
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done=1 expected no frame at %0t", $time);
                end else begin
                    e = q.pop_front();
                    check("gnt_at_grant", int'(cur_gnt), int'(e.gnt));
                    check("gnt_at_report", int'(gnt), int'(e.gnt));
                    check("latency", nbits, int'(FB));
                    check("a_bits", int'(abits[FB-1:0]), int'(e.bits));
                    check("hit", int'(hit), int'(e.hit));
                    if (e.spacing != 0) check("grant_spacing", spacing, e.spacing);
                end
                in_frame = 1'b0;
                post_done = 1'b1;
            end
        end
        prev_gnt = gnt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_a", int'(a), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_hit", int'(hit), 0);
`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
        check("rst_match_cnt", int'(match_cnt), 0);
`endif
        mon_en = 1'b1;
        reset_n = 1'b1;

        // Basic match, then mismatch, then lone requester 1.
        frame(2'b01, 4'b0100, 4'b0000, 4'b0100, 2'b01, 4'b0100, 1'b1, 0);
        frame(2'b01, 4'b0101, 4'b1111, 4'b0100, 2'b01, 4'b0101, 1'b0, 6);
        frame(2'b10, 4'b0000, 4'b1011, 4'b1011, 2'b10, 4'b1011, 1'b1, 6);

        // Contention held for three frames: 01, 10, 01 at six-cycle spacing.
        expect_frame(2'b01, 4'b0110, 1'b1, 6);
        expect_frame(2'b10, 4'b1001, 1'b0, 6);
        expect_frame(2'b01, 4'b0110, 1'b1, 6);
        req = 2'b11;
        word0 = 4'b0110;
        word1 = 4'b1001;
        pattern = 4'b0110;
        @(posedge clk);
        repeat (12) @(posedge clk);
        #1 req = 2'b00;
        repeat (FB + 1) @(posedge clk);
        #1;

        // Inputs changed right after the grant must not affect the frame.
        expect_frame(2'b01, 4'b0011, 1'b1, 6);
        req = 2'b01;
        word0 = 4'b0011;
        pattern = 4'b0011;
        @(posedge clk);
        #1;
        req = 2'b00;
        word0 = 4'b1111;
        pattern = 4'b0000;
        repeat (FB + 1) @(posedge clk);
        #1;

        // Reset mid-frame: pointer is 1, so requester 1 gets this grant, then aborts.
        req = 2'b11;
        word0 = 4'b0001;
        word1 = 4'b0010;
        pattern = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        check("abort_gnt", int'(gnt), 0);
        check("abort_a", int'(a), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_hit", int'(hit), 0);
`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
        check("abort_match_cnt", int'(match_cnt), 0);
`endif
        expect_frame(2'b01, 4'b0001, 1'b1, 3);
        @(posedge clk);
        #1 req = 2'b00;
        repeat (FB + 1) @(posedge clk);
        #1;

`ifdef SEQ_DETECT_ARB_MATCH_CNT_EN
        check("match_cnt_one", int'(match_cnt), 1);
        for (int i = 0; i < 300; i++) begin
            expect_frame(2'b01, 4'b1010, 1'b1, (i == 0) ? 0 : 6);
        end
        req = 2'b01;
        word0 = 4'b1010;
        pattern = 4'b1010;
        @(posedge clk);
        repeat (6 * 299) @(posedge clk);
        #1 req = 2'b00;
        repeat (FB + 1) @(posedge clk);
        #1;
        check("match_cnt_sat", int'(match_cnt), 255);
        frame(2'b01, 4'b1010, 4'b0000, 4'b1010, 2'b01, 4'b1010, 1'b1, 6);
        check("match_cnt_hold", int'(match_cnt), 255);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
